// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-pin 2-flop synchroniser, tick-based debouncer,
// sticky rise/fall pending flags and a single OR-reduced interrupt line.
// Optional feature macro: GPIO_DEB_BYPASS_EN adds the deb_bypass input, which
// lets selected pins skip the debouncer and follow the synchronised level.
module gpio_input_conditioner #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PRESC      = 1000,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_clr,
`ifdef GPIO_DEB_BYPASS_EN
    input  logic [WIDTH-1:0] deb_bypass,
`endif
    output logic [WIDTH-1:0] pin_deb,
    output logic [WIDTH-1:0] edge_pend,
    output logic             irq
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned CW = ($clog2(DEB_CYCLES + 1) > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [PW-1:0]    presc_cnt;
    logic             tick;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] deb_nxt;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] byp;

`ifdef GPIO_DEB_BYPASS_EN
    assign byp = deb_bypass;
`else
    assign byp = '0;
`endif

    // Sample tick on the last count of each prescaler period.
    assign tick = (presc_cnt == PW'(PRESC - 1));

    // Per-pin debounce: a changed level must persist for DEB_CYCLES ticks.
    always_comb begin
        deb_nxt = pin_deb;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (byp[i]) begin
                deb_nxt[i] = s2[i];
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (s2[i] == pin_deb[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_nxt[i] = s2[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Edge events on the debounced level; set wins over write-1-to-clear.
    assign rise_ev  = deb_nxt & ~pin_deb & rise_en;
    assign fall_ev  = ~deb_nxt & pin_deb & fall_en;
    assign pend_nxt = (edge_pend & ~irq_clr) | rise_ev | fall_ev;
    assign irq      = |edge_pend;

    // State registers: synchroniser, prescaler, counters, level and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            presc_cnt <= '0;
            pin_deb   <= '0;
            edge_pend <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= pin_in;
            s2        <= s1;
            presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
            pin_deb   <= deb_nxt;
            edge_pend <= pend_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
